// File: rtl/adc_fsm_10b_pkg.sv
// Shared types and constants for the 10-bit SAR ADC controller.
package adc_fsm_10b_pkg;
    localparam int N_BITS   = 10;
    localparam int MIDSCALE = 512;
    localparam int OFS_W    = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_TRIAL,
        ST_WAIT,
        ST_DECIDE,
        ST_CORRECT,
        ST_DONE
    } state_t;
endpackage

// File: rtl/adc_offset_corrector.sv
// Subtracts the calibrated offset from a raw SAR code and clamps to the code range.
module adc_offset_corrector #(
    parameter int W = adc_fsm_10b_pkg::N_BITS
) (
    input  logic [W-1:0]        raw,
    input  logic signed [W:0]   offset,
    output logic [W-1:0]        corrected
);
    logic signed [W+1:0] diff;

    // Two guard bits: the difference spans -(2^W - 1) .. 2^(W+1) - 1.
    assign diff = $signed({2'b00, raw}) - $signed({offset[W], offset});

    always_comb begin
        corrected = diff[W-1:0];
        if (diff[W+1]) begin
            corrected = '0;
        end else if (diff[W]) begin
            corrected = '1;
        end
    end
endmodule

// File: rtl/adc_fsm_10b.sv
// SAR ADC sequencer: sample, bit-by-bit trials, offset calibration/correction.
module adc_fsm_10b #(
    parameter int N_BITS        = adc_fsm_10b_pkg::N_BITS,
    parameter int SAMPLE_CYCLES = 2
) (
    input  logic                          clkin,
    input  logic                          rst,
    input  logic                          st_conv,
    input  logic                          cal,
    input  logic                          sel_12b,
    input  logic                          comp_in,
    output logic                          clkout,
    output logic                          sample,
    output logic [N_BITS-1:0]             dac_value,
    output logic [N_BITS-N_BITS/2-1:0]    dac_msb,
    output logic [N_BITS/2-1:0]           dac_lsb,
    output logic [N_BITS-1:0]             result,
    output logic                          adc_done,
    output adc_fsm_10b_pkg::state_t       dbg_state
);
    import adc_fsm_10b_pkg::*;

    localparam int PTR_W = $clog2(N_BITS);
    localparam int CNT_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam logic [PTR_W-1:0]  TOP_PTR  = PTR_W'(N_BITS - 1);
    localparam logic [PTR_W-1:0]  FAST_PTR = PTR_W'(N_BITS - 8);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [N_BITS:0]   MID_CODE = {2'b01, {(N_BITS-1){1'b0}}};

    state_t                 state, state_nx;
    logic [PTR_W-1:0]       ptr, last_ptr;
    logic [N_BITS-1:0]      sar, trial_code, corrected;
    logic [CNT_W-1:0]       samp_cnt;
    logic                   cal_q, fast_q, start;
    logic signed [N_BITS:0] offset_q;

    // Handshake: st_conv is a request taken only in IDLE/DONE; adc_done then
    // stays high until the next accepted request.
    assign trial_code = sar | ({{(N_BITS-1){1'b0}}, 1'b1} << ptr);
    assign last_ptr   = fast_q ? FAST_PTR : '0;
    assign dac_msb    = dac_value[N_BITS-1:N_BITS/2];
    assign dac_lsb    = dac_value[N_BITS/2-1:0];
    assign dbg_state  = state;

    always_ff @(posedge clkin) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        start     = 1'b0;
        clkout    = 1'b0;
        sample    = 1'b0;
        dac_value = '0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (state == ST_DONE) dac_value = sar;
                if (st_conv) begin
                    start    = 1'b1;
                    state_nx = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                sample = 1'b1;
                if (samp_cnt == CNT_LAST) state_nx = ST_TRIAL;
            end
            ST_TRIAL: begin
                clkout    = 1'b1;
                dac_value = trial_code;
                state_nx  = ST_WAIT;
            end
            ST_WAIT: begin
                dac_value = trial_code;
                state_nx  = ST_DECIDE;
            end
            ST_DECIDE: begin
                dac_value = trial_code;
                state_nx  = (ptr == last_ptr) ? ST_CORRECT : ST_TRIAL;
            end
            ST_CORRECT: begin
                dac_value = sar;
                state_nx  = ST_DONE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Mode select is latched with cal so a mid-conversion change cannot cut the bit walk short.
    always_ff @(posedge clkin) begin
        if (rst) begin
            sar      <= '0;
            ptr      <= TOP_PTR;
            samp_cnt <= '0;
            cal_q    <= 1'b0;
            fast_q   <= 1'b0;
            offset_q <= '0;
            result   <= '0;
            adc_done <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        sar      <= '0;
                        ptr      <= TOP_PTR;
                        samp_cnt <= '0;
                        cal_q    <= cal;
                        fast_q   <= ~sel_12b;
                        adc_done <= 1'b0;
                    end else if (state == ST_DONE) begin
                        adc_done <= 1'b1;
                    end
                end
                ST_SAMPLE: samp_cnt <= samp_cnt + 1'b1;
                ST_DECIDE: begin
                    if (comp_in) sar <= trial_code;
                    if (ptr != last_ptr) ptr <= ptr - 1'b1;
                end
                ST_CORRECT: begin
                    if (cal_q) begin
                        offset_q <= $signed({1'b0, sar} - MID_CODE);
                        result   <= sar;
                    end else begin
                        result   <= corrected;
                    end
                end
                default: ;
            endcase
        end
    end

    adc_offset_corrector #(.W(N_BITS)) u_corr (
        .raw       (sar),
        .offset    (offset_q),
        .corrected (corrected)
    );
endmodule

// File: tb/tb_adc_fsm_10b.sv
// Bench for adc_fsm_10b: comparator plant model, reference SAR/offset model, scenario tasks.
module tb_adc_fsm_10b;
    import adc_fsm_10b_pkg::*;

    localparam int SC      = 2;
    localparam int TIMEOUT = 100;

    logic        clkin = 1'b0;
    logic        rst, st_conv, cal, sel_12b, comp_in;
    logic        clkout, sample, adc_done;
    logic [9:0]  dac_value, result;
    logic [4:0]  dac_msb, dac_lsb;
    state_t      dbg_state;

    int          ref_val = 0;
    int          cmp_off = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          exp_offset = 0;
    logic [9:0]  exp_q[$];
    logic [9:0]  last_exp = '0;

    always #5 clkin = ~clkin;

    // Comparator with an optional input-referred offset.
    assign comp_in = (ref_val >= int'(dac_value) + cmp_off);

    adc_fsm_10b #(.N_BITS(10), .SAMPLE_CYCLES(SC)) dut (
        .clkin     (clkin),
        .rst       (rst),
        .st_conv   (st_conv),
        .cal       (cal),
        .sel_12b   (sel_12b),
        .comp_in   (comp_in),
        .clkout    (clkout),
        .sample    (sample),
        .dac_value (dac_value),
        .dac_msb   (dac_msb),
        .dac_lsb   (dac_lsb),
        .result    (result),
        .adc_done  (adc_done),
        .dbg_state (dbg_state)
    );

    // Ideal SAR outcome: largest grid code c with the comparator saying ref >= c + off.
    function automatic int model_raw(int r, int off, logic full);
        int step = full ? 1 : 4;
        int best = 0;
        for (int c = 0; c < 1024; c += step)
            if (c + off <= r) best = c;
        return best;
    endfunction

    task automatic model_push(input int raw, input logic cal_v);
        int r;
        if (cal_v) begin
            exp_offset = raw - 512;
            exp_q.push_back(10'(raw));
        end else begin
            r = raw - exp_offset;
            if (r < 0) r = 0;
            if (r > 1023) r = 1023;
            exp_q.push_back(10'(r));
        end
    endtask

    // Driver: called #1 after an edge; returns #1 after the edge that shows adc_done.
    task automatic do_conv(input int r, input int off, input logic cal_v, input logic sel_v,
                           output int lat, output int pulses,
                           output logic [9:0] res, output logic [9:0] dac);
        ref_val = r; cmp_off = off; cal = cal_v; sel_12b = sel_v; st_conv = 1'b1;
        @(posedge clkin); #1;
        st_conv = 1'b0;
        cal = ~cal_v;
        lat = 0; pulses = 0;
        while (adc_done !== 1'b1 && lat < TIMEOUT) begin
            if (clkout === 1'b1) pulses++;
            @(posedge clkin); #1;
            lat++;
        end
        res = result;
        dac = dac_value;
    endtask

    task automatic test_reset();
        rst = 1'b1; st_conv = 1'b1; cal = 1'b0; sel_12b = 1'b1;
        repeat (3) @(posedge clkin);
        #1;
        n_cmp++; if (clkout !== 1'b0) begin n_err++; $display("FAIL reset_clkout: got %0b want 0", clkout); end
        n_cmp++; if (sample !== 1'b0) begin n_err++; $display("FAIL reset_sample: got %0b want 0", sample); end
        n_cmp++; if (dac_value !== 10'd0) begin n_err++; $display("FAIL reset_dac: got %0d want 0", dac_value); end
        n_cmp++; if (result !== 10'd0) begin n_err++; $display("FAIL reset_result: got %0d want 0", result); end
        n_cmp++; if (adc_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0b want 0", adc_done); end
        n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
        rst = 1'b0; st_conv = 1'b0;
        @(posedge clkin); #1;
        n_cmp++; if (sample !== 1'b0) begin n_err++; $display("FAIL rst_beats_start: sample got %0b want 0", sample); end
        exp_offset = 0;
    endtask

    task automatic test_ideal();
        int lat, pulses, raw;
        logic [9:0] res, dac, exp;
        do_conv(300, 0, 1'b0, 1'b1, lat, pulses, res, dac);
        raw = model_raw(300, 0, 1'b1);
        model_push(raw, 1'b0);
        exp = exp_q.pop_front(); last_exp = exp;
        n_cmp++; if (res !== exp) begin n_err++; $display("FAIL ideal_result: got %0d want %0d", res, exp); end
        n_cmp++; if (lat != SC + 32) begin n_err++; $display("FAIL ideal_latency: got %0d want %0d", lat, SC + 32); end
        n_cmp++; if (pulses != 10) begin n_err++; $display("FAIL ideal_clkout_pulses: got %0d want 10", pulses); end
        n_cmp++; if (dac !== 10'(raw)) begin n_err++; $display("FAIL ideal_dac_hold: got %0d want %0d", dac, raw); end
        n_cmp++; if ({dac_msb, dac_lsb} !== 10'(raw)) begin n_err++; $display("FAIL ideal_dac_split: got %0d/%0d want %0d", dac_msb, dac_lsb, raw); end
    endtask

    task automatic test_random_ideal();
        int lat, pulses, raw, r;
        logic [9:0] res, dac, exp;
        repeat (6) begin
            r = $urandom_range(0, 1023);
            do_conv(r, 0, 1'b0, 1'b1, lat, pulses, res, dac);
            raw = model_raw(r, 0, 1'b1);
            model_push(raw, 1'b0);
            exp = exp_q.pop_front(); last_exp = exp;
            n_cmp++; if (res !== exp) begin n_err++; $display("FAIL rand_ideal_result ref=%0d: got %0d want %0d", r, res, exp); end
            n_cmp++; if (dac !== 10'(raw)) begin n_err++; $display("FAIL rand_ideal_dac ref=%0d: got %0d want %0d", r, dac, raw); end
        end
    endtask

    task automatic test_fast_mode();
        int lat, pulses, raw, r;
        logic [9:0] res, dac, exp;
        for (int i = 0; i < 4; i++) begin
            r = (i == 0) ? 301 : int'($urandom_range(0, 1023));
            do_conv(r, 0, 1'b0, 1'b0, lat, pulses, res, dac);
            raw = model_raw(r, 0, 1'b0);
            model_push(raw, 1'b0);
            exp = exp_q.pop_front(); last_exp = exp;
            n_cmp++; if (res !== exp) begin n_err++; $display("FAIL fast_result ref=%0d: got %0d want %0d", r, res, exp); end
            n_cmp++; if (dac !== 10'(raw)) begin n_err++; $display("FAIL fast_dac ref=%0d: got %0d want %0d", r, dac, raw); end
            n_cmp++; if (pulses != 8) begin n_err++; $display("FAIL fast_clkout_pulses: got %0d want 8", pulses); end
            n_cmp++; if (lat != SC + 26) begin n_err++; $display("FAIL fast_latency: got %0d want %0d", lat, SC + 26); end
        end
    endtask

    task automatic test_calibration();
        int lat, pulses, raw;
        logic [9:0] res, dac, exp;
        int refs[4] = '{512, 300, 1023, 50};
        for (int i = 0; i < 4; i++) begin
            do_conv(refs[i], 100, (i == 0), 1'b1, lat, pulses, res, dac);
            raw = model_raw(refs[i], 100, 1'b1);
            model_push(raw, (i == 0));
            exp = exp_q.pop_front(); last_exp = exp;
            n_cmp++; if (res !== exp) begin n_err++; $display("FAIL cal_result ref=%0d: got %0d want %0d", refs[i], res, exp); end
            n_cmp++; if (dac !== 10'(raw)) begin n_err++; $display("FAIL cal_raw ref=%0d: got %0d want %0d", refs[i], dac, raw); end
        end
    endtask

    task automatic test_mid_reset();
        int lat, pulses, raw;
        logic [9:0] res, dac, exp;
        ref_val = 600; cmp_off = 0; cal = 1'b0; sel_12b = 1'b1; st_conv = 1'b1;
        @(posedge clkin); #1;
        st_conv = 1'b0;
        lat = 0; pulses = 0;
        while (lat < TIMEOUT) begin
            if (clkout === 1'b1) begin
                pulses++;
                if (pulses == 5) break;
            end
            @(posedge clkin); #1;
            lat++;
        end
        n_cmp++; if (pulses != 5) begin n_err++; $display("FAIL midrst_reach_trial5: got %0d trials want 5", pulses); end
        rst = 1'b1;
        @(posedge clkin); #1;
        rst = 1'b0;
        exp_offset = 0;
        n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL midrst_state: got %0d want %0d", dbg_state, ST_IDLE); end
        n_cmp++; if ({clkout, sample, adc_done} !== 3'b000) begin n_err++; $display("FAIL midrst_ctrl: got %03b want 000", {clkout, sample, adc_done}); end
        n_cmp++; if (dac_value !== 10'd0) begin n_err++; $display("FAIL midrst_dac: got %0d want 0", dac_value); end
        n_cmp++; if (result !== 10'd0) begin n_err++; $display("FAIL midrst_result: got %0d want 0", result); end
        do_conv(700, 0, 1'b0, 1'b1, lat, pulses, res, dac);
        raw = model_raw(700, 0, 1'b1);
        model_push(raw, 1'b0);
        exp = exp_q.pop_front(); last_exp = exp;
        n_cmp++; if (res !== exp) begin n_err++; $display("FAIL midrst_next_result: got %0d want %0d", res, exp); end
    endtask

    task automatic test_random_cal();
        int lat, pulses, raw, r, off;
        logic cal_v, sel_v;
        logic [9:0] res, dac, exp;
        repeat (8) begin
            r = $urandom_range(0, 1023);
            off = $urandom_range(0, 120);
            cal_v = 1'($urandom_range(0, 1));
            sel_v = 1'($urandom_range(0, 1));
            do_conv(r, off, cal_v, sel_v, lat, pulses, res, dac);
            raw = model_raw(r, off, sel_v);
            model_push(raw, cal_v);
            exp = exp_q.pop_front(); last_exp = exp;
            n_cmp++; if (res !== exp) begin n_err++; $display("FAIL rand_cal_result ref=%0d off=%0d cal=%0b: got %0d want %0d", r, off, cal_v, res, exp); end
            n_cmp++; if (lat != (sel_v ? SC + 32 : SC + 26)) begin n_err++; $display("FAIL rand_cal_latency: got %0d", lat); end
        end
    endtask

    task automatic test_ignored_start();
        int r, raw, rises, held_bad, lat_done;
        logic prev_done;
        logic [9:0] exp;
        r = $urandom_range(100, 900);
        ref_val = r; cmp_off = 0; cal = 1'b0; sel_12b = 1'b1; st_conv = 1'b1;
        @(posedge clkin); #1;
        st_conv = 1'b0;
        raw = model_raw(r, 0, 1'b1);
        model_push(raw, 1'b0);
        exp = exp_q.pop_front();
        rises = 0; held_bad = 0; lat_done = -1; prev_done = adc_done;
        for (int k = 0; k < 50; k++) begin
            if (adc_done === 1'b1 && prev_done !== 1'b1) begin
                rises++;
                if (lat_done < 0) lat_done = k;
            end
            if (k < SC + 31 && result !== last_exp) held_bad++;
            prev_done = adc_done;
            st_conv = (k == 5 || k == 12 || k == 20 || k == 31);
            @(posedge clkin); #1;
        end
        st_conv = 1'b0;
        n_cmp++; if (rises != 1) begin n_err++; $display("FAIL ignored_done_rises: got %0d want 1", rises); end
        n_cmp++; if (lat_done != SC + 32) begin n_err++; $display("FAIL ignored_latency: got %0d want %0d", lat_done, SC + 32); end
        n_cmp++; if (held_bad != 0) begin n_err++; $display("FAIL ignored_result_held: got %0d changes want 0", held_bad); end
        n_cmp++; if (result !== exp) begin n_err++; $display("FAIL ignored_result: got %0d want %0d", result, exp); end
        last_exp = exp;
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_random_ideal();
        test_fast_mode();
        test_calibration();
        test_mid_reset();
        test_random_cal();
        test_ignored_start();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
